// File: rtl/tdc_meas_pkg.sv
// Shared types, default widths and the saturating-add helper for the TDC measurement sequencer.
// Latency: n/a (package). Backpressure: n/a.
// Consumers override the widths per instance; these are the defaults only.
package tdc_meas_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int WIN_W_DEF  = 12;
    localparam int NWIN_W_DEF = 4;
    localparam int ACC_W_DEF  = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // Returns {overflow, sum clamped to 2^w-1}; valid for w up to 31.
    function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        if (sum > lim) begin
            return {1'b1, lim[31:0]};
        end
        return {1'b0, sum[31:0]};
    endfunction

endpackage

// File: rtl/tdc_window_timer.sv
// Loadable down-counter timing the gate and settle intervals of a measurement window.
// Latency: load takes effect next cycle; last is high during the final counted cycle.
// Backpressure: none; load has priority over decrement.
module tdc_window_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/tdc_meas_sequencer.sv
// Runs the data counter through N gated windows and sums the per-window counts (TDC_MEAS_MINMAX_EN adds min/max).
// Latency: result_valid N*(window_len+SETTLE+2)+1 cycles after start is sampled; 1 cycle for a degenerate config.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next edge.
module tdc_meas_sequencer
    import tdc_meas_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WIN_W  = WIN_W_DEF,
    parameter int NWIN_W = NWIN_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WIN_W-1:0]  window_len,
    input  logic [NWIN_W-1:0] num_windows,
    input  logic [CNT_W-1:0]  count_in,
    output logic              cnt_clear,
    output logic              cnt_en,
    output logic              busy,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              overflow,
    output logic              aborted
`ifdef TDC_MEAS_MINMAX_EN
    ,
    output logic [CNT_W-1:0]  min_cnt,
    output logic [CNT_W-1:0]  max_cnt
`endif
);

    state_t             state;
    logic [WIN_W-1:0]   len_q;
    logic [NWIN_W-1:0]  nwin_q;
    logic [NWIN_W-1:0]  idx;
    logic [ACC_W-1:0]   acc;

    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_last;
    logic [WIN_W-1:0]   tmr_val;

    logic [32:0]        sat_res;
    logic [ACC_W-1:0]   acc_nxt;
    logic               sat_ovf;
    logic               sat_unused;
    logic               last_win;
    logic               degen;

    // One timer serves both intervals: reloaded with SETTLE on the final gate cycle.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = len_q;
        case (state)
            ST_CLEAR: tmr_load = 1'b1;
            ST_GATE: begin
                tmr_dec = 1'b1;
                if (tmr_last && SETTLE != 0) begin
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(SETTLE);
                end
            end
            ST_SETTLE: tmr_dec = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        sat_res  = sat_add(32'(acc), 32'(count_in), ACC_W);
        acc_nxt  = sat_res[ACC_W-1:0];
        sat_ovf  = sat_res[32];
        last_win = (idx == nwin_q - NWIN_W'(1));
        degen    = (num_windows == '0) || (window_len == '0);
    end

    assign sat_unused = ^sat_res[31:ACC_W];

    tdc_window_timer #(
        .W(WIN_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .last     (tmr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt_clear    <= 1'b0;
            cnt_en       <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            aborted      <= 1'b0;
            len_q        <= '0;
            nwin_q       <= '0;
            idx          <= '0;
            acc          <= '0;
        end else begin
            cnt_clear    <= 1'b0;
            result_valid <= 1'b0;
            aborted      <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state   <= ST_IDLE;
                cnt_en  <= 1'b0;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            len_q    <= window_len;
                            nwin_q   <= num_windows;
                            acc      <= '0;
                            idx      <= '0;
                            overflow <= 1'b0;
                            busy     <= 1'b1;
                            if (degen) begin
                                result       <= '0;
                                result_valid <= 1'b1;
                                state        <= ST_DONE;
                            end else begin
                                cnt_clear <= 1'b1;
                                state     <= ST_CLEAR;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        cnt_en <= 1'b1;
                        state  <= ST_GATE;
                    end
                    ST_GATE: begin
                        if (tmr_last) begin
                            cnt_en <= 1'b0;
                            state  <= (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (tmr_last) begin
                            state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        acc <= acc_nxt;
                        if (sat_ovf) begin
                            overflow <= 1'b1;
                        end
                        // result/result_valid are registered so they are visible during DONE.
                        if (last_win) begin
                            result       <= acc_nxt;
                            result_valid <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            idx       <= idx + NWIN_W'(1);
                            cnt_clear <= 1'b1;
                            state     <= ST_CLEAR;
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef TDC_MEAS_MINMAX_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;
    logic [CNT_W-1:0] min_nxt;
    logic [CNT_W-1:0] max_nxt;
    logic             first_win;

    always_comb begin
        first_win = (idx == '0);
        min_nxt   = (first_win || count_in < min_q) ? count_in : min_q;
        max_nxt   = (first_win || count_in > max_q) ? count_in : max_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q   <= '0;
            max_q   <= '0;
            min_cnt <= '0;
            max_cnt <= '0;
        end else if (!abort) begin
            if (state == ST_IDLE && start && degen) begin
                min_cnt <= '0;
                max_cnt <= '0;
            end
            if (state == ST_CAPTURE) begin
                min_q <= min_nxt;
                max_q <= max_nxt;
                if (last_win) begin
                    min_cnt <= min_nxt;
                    max_cnt <= max_nxt;
                end
            end
        end
    end
`else
    // Without min/max tracking each window count only feeds the accumulator.
`endif

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Randomised and directed check of tdc_meas_sequencer against a window-arithmetic reference model.
// The external data counter is modelled as presetting to a chosen base on cnt_clear and counting on cnt_en.
module tb_tdc_meas_sequencer;

    localparam int CNT_W    = 8;
    localparam int WIN_W    = 12;
    localparam int NWIN_W   = 4;
    localparam int ACC_W    = 8;
    localparam int SETTLE_C = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [WIN_W-1:0]  window_len;
    logic [NWIN_W-1:0] num_windows;
    logic [CNT_W-1:0]  count_in;
    logic              cnt_clear;
    logic              cnt_en;
    logic              busy;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              overflow;
    logic              aborted;
`ifdef TDC_MEAS_MINMAX_EN
    logic [CNT_W-1:0]  min_cnt;
    logic [CNT_W-1:0]  max_cnt;
`endif

    int n_total    = 0;
    int n_bad      = 0;
    int exp_result = 0;
    int base_q[16];

    always #5 clk = ~clk;

    tdc_meas_sequencer #(
        .CNT_W  (CNT_W),
        .WIN_W  (WIN_W),
        .NWIN_W (NWIN_W),
        .ACC_W  (ACC_W),
        .SETTLE (SETTLE_C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .window_len   (window_len),
        .num_windows  (num_windows),
        .count_in     (count_in),
        .cnt_clear    (cnt_clear),
        .cnt_en       (cnt_en),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow),
        .aborted      (aborted)
`ifdef TDC_MEAS_MINMAX_EN
        ,
        .min_cnt      (min_cnt),
        .max_cnt      (max_cnt)
`endif
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge (cycle t0), k counts cycles after it.
    task automatic do_run(input string tag, input int len, input int nwin, input int abort_k);
        int p, t_done, sum, psum, cnt, widx, c, w, r;
        int e_clr, e_en, e_busy, e_vld, e_abt;
        bit degen, clr_exp, en_exp;
`ifdef TDC_MEAS_MINMAX_EN
        int mn, mx;
        mn = 0;
        mx = 0;
`endif
        degen  = (len == 0) || (nwin == 0);
        p      = len + SETTLE_C + 2;
        t_done = degen ? 1 : 1 + nwin * p;
        sum    = 0;
        psum   = 0;
        if (!degen) begin
            for (int i = 0; i < nwin; i++) begin
                c = (base_q[i] + len) % 256;
                sum += c;
                if (abort_k != 0 && (i + 1) * p < abort_k) psum += c;
`ifdef TDC_MEAS_MINMAX_EN
                if (i == 0 || c < mn) mn = c;
                if (i == 0 || c > mx) mx = c;
`endif
            end
        end
        e_clr = 0; e_en = 0; e_busy = 0; e_vld = 0; e_abt = 0;
        cnt = 0;
        widx = 0;
        window_len  = WIN_W'(len);
        num_windows = NWIN_W'(nwin);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= t_done + 1; k++) begin
            if (abort_k != 0 && k == abort_k + 1) begin
                check_eq({tag, ".aborted"}, int'(aborted), 1);
                check_eq({tag, ".abort_en"}, int'(cnt_en), 0);
                check_eq({tag, ".abort_busy"}, int'(busy), 0);
                check_eq({tag, ".abort_vld"}, int'(result_valid), 0);
                check_eq({tag, ".abort_res"}, int'(result), exp_result);
                check_eq({tag, ".abort_ovf"}, int'(overflow), (psum > 255) ? 1 : 0);
                abort = 1'b0;
                start = 1'b0;
                break;
            end
            w = (k - 1) / p;
            r = (k - 1) % p;
            clr_exp = !degen && w < nwin && r == 0;
            en_exp  = !degen && w < nwin && r >= 1 && r <= len;
            if (cnt_clear !== clr_exp) e_clr++;
            if (cnt_en !== en_exp) e_en++;
            if (busy !== (k <= t_done)) e_busy++;
            if (result_valid !== (k == t_done)) e_vld++;
            if (aborted !== 1'b0) e_abt++;
            if (k == t_done) begin
                exp_result = degen ? 0 : ((sum > 255) ? 255 : sum);
                check_eq({tag, ".result"}, int'(result), exp_result);
                check_eq({tag, ".overflow"}, int'(overflow), (!degen && sum > 255) ? 1 : 0);
`ifdef TDC_MEAS_MINMAX_EN
                check_eq({tag, ".min"}, int'(min_cnt), mn);
                check_eq({tag, ".max"}, int'(max_cnt), mx);
`endif
            end
            if (cnt_clear) begin
                cnt = base_q[widx % 16];
                widx++;
            end else if (cnt_en) begin
                cnt = (cnt + 1) % 256;
            end
            count_in = CNT_W'(cnt);
            if (t_done >= 4 && k == 2) begin
                start       = 1'b1;
                window_len  = WIN_W'($urandom);
                num_windows = NWIN_W'($urandom);
            end
            if (k == 3) start = 1'b0;
            if (k == abort_k) abort = 1'b1;
            if (k <= t_done) @(negedge clk);
        end
        check_eq({tag, ".clr_pattern_errs"}, e_clr, 0);
        check_eq({tag, ".en_pattern_errs"}, e_en, 0);
        check_eq({tag, ".busy_pattern_errs"}, e_busy, 0);
        check_eq({tag, ".valid_pattern_errs"}, e_vld, 0);
        check_eq({tag, ".aborted_glitches"}, e_abt, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        window_len = '0; num_windows = '0; count_in = '0;
        for (int j = 0; j < 16; j++) base_q[j] = 0;
        repeat (3) @(negedge clk);
        check_eq("reset.flags", int'({cnt_clear, cnt_en, busy, result_valid, overflow, aborted}), 0);
        check_eq("reset.result", int'(result), 0);
        rst = 1'b0;
        @(negedge clk);

        do_run("normal", 4, 3, 0);

        window_len = 12'd5; num_windows = 4'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("rst_mid.gate_en", int'(cnt_en), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid.flags", int'({cnt_clear, cnt_en, busy, result_valid, overflow, aborted}), 0);
        check_eq("rst_mid.result", int'(result), 0);
        rst = 1'b0;
        exp_result = 0;
        @(negedge clk);

        base_q[0] = 196; base_q[1] = 96;
        do_run("sat", 4, 2, 0);
        base_q[0] = 0; base_q[1] = 0;
        do_run("sat_clear", 3, 2, 0);

        do_run("abort", 4, 3, 11);
        do_run("after_abort", 2, 2, 0);

        do_run("degen_nwin", 4, 0, 0);
        do_run("degen_len", 0, 3, 0);

        window_len = 12'd4; num_windows = 4'd2;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        check_eq("start_abort.busy", int'(busy), 0);
        check_eq("start_abort.clr", int'(cnt_clear), 0);
        check_eq("start_abort.aborted", int'(aborted), 0);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_eq("start_abort.idle", int'(busy), 0);

        base_q[0] = 6; base_q[1] = 1; base_q[2] = 8;
        do_run("minmax", 1, 3, 0);

        for (int it = 0; it < 30; it++) begin
            int len, nwin, td, ak;
            len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            nwin = int'($urandom_range(0, 5));
            for (int j = 0; j < 16; j++) base_q[j] = int'($urandom_range(0, 255));
            td = (len == 0 || nwin == 0) ? 1 : 1 + nwin * (len + SETTLE_C + 2);
            ak = (td > 4 && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, td - 1)) : 0;
            do_run("rand", len, nwin, ak);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
